seq_match_logger: RTL and testbench

- Sits directly downstream of the serial "101" Mealy sequence detector and consumes its single-cycle `match` pulse.
- Opens a capture window of WINDOW bit-cycles on `start`.
- Within the window it counts detections and logs the bit position of each detection into a small FIFO.
- Control/debug logic drains the FIFO through a valid/ready read port.

---
 rtl/seq_match_logger.sv | 119 +++++++++++
 tb/tb_seq_match_logger.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_match_logger.sv
// Capture-window logger for the serial "101" detector: counts match pulses
// during a WINDOW-cycle run and queues the bit position of each one.
module seq_match_logger #(
  parameter int WINDOW = 64,
  parameter int POS_W  = 16,
  parameter int CNT_W  = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     start,
  input  logic                     match,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         count,
  output logic                     overflow,
  output logic                     ev_valid,
  output logic [POS_W-1:0]         ev_pos,
  input  logic                     ev_ready,
  output logic [$clog2(DEPTH):0]   level
);

  // state  | meaning
  // IDLE   | no window open, waiting for start
  // RUN    | window open, pos advancing, matches captured
  // DONE   | window closed, results held, waiting for start
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam int AW = $clog2(DEPTH);

  state_t           state;
  state_t           state_nx;
  logic             start_acc;
  logic [POS_W-1:0] pos;
  logic             last;
  logic             capture;
  logic             full;
  logic             pop;
  logic             push_ok;
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [POS_W-1:0] mem [DEPTH];

  assign last = (pos == POS_W'(WINDOW - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    start_acc = 1'b0;
    if (clear) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state_nx  = S_RUN;
          start_acc = 1'b1;
        end
        S_RUN:  if (last) state_nx = S_DONE;
        S_DONE: if (start) begin
          state_nx  = S_RUN;
          start_acc = 1'b1;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level    = wr_ptr - rd_ptr;
  assign ev_valid = (level != '0);
  assign full     = (level == (AW + 1)'(DEPTH));
  assign ev_pos   = mem[rd_ptr[AW-1:0]];

  assign capture = busy && match && !clear;
  assign pop     = ev_valid && ev_ready;
  assign push_ok = capture && (!full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos      <= '0;
      count    <= '0;
      overflow <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear || start_acc) begin
      pos      <= '0;
      count    <= '0;
      overflow <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (busy && !last) pos <= pos + POS_W'(1);
      if (capture) begin
        if (count != '1) count <= count + CNT_W'(1);
        if (push_ok) begin
          mem[wr_ptr[AW-1:0]] <= pos;
          wr_ptr              <= wr_ptr + (AW + 1)'(1);
        end else begin
          overflow <= 1'b1;
        end
      end
      if (pop) rd_ptr <= rd_ptr + (AW + 1)'(1);
    end
  end

endmodule

// File: tb/tb_seq_match_logger.sv
// Directed bench for seq_match_logger: a per-cycle vector table for the basic
// window, then hand-written sequences for overflow, saturation, clear and reset.
module tb_seq_match_logger;

  logic        clk = 1'b0;
  logic        rst, clear, start, match, ev_ready;
  logic        busy, done, overflow, ev_valid;
  logic [7:0]  count;
  logic [15:0] ev_pos;
  logic [2:0]  level;
  logic        s_busy, s_done, s_overflow, s_ev_valid;
  logic [1:0]  s_count;
  logic [15:0] s_ev_pos;
  logic [2:0]  s_level;

  int checks = 0;
  int errors = 0;

  logic [15:0] popped[$];
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  seq_match_logger #(.WINDOW(16), .POS_W(16), .CNT_W(8), .DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .clear(clear), .start(start), .match(match),
    .busy(busy), .done(done), .count(count), .overflow(overflow),
    .ev_valid(ev_valid), .ev_pos(ev_pos), .ev_ready(ev_ready), .level(level)
  );

  // Same stimulus, 2-bit counter to exercise saturation.
  seq_match_logger #(.WINDOW(16), .POS_W(16), .CNT_W(2), .DEPTH(4)) u_sat (
    .clk(clk), .rst(rst), .clear(clear), .start(start), .match(match),
    .busy(s_busy), .done(s_done), .count(s_count), .overflow(s_overflow),
    .ev_valid(s_ev_valid), .ev_pos(s_ev_pos), .ev_ready(ev_ready), .level(s_level)
  );

  typedef struct {
    logic        s, m, r, c;
    logic        busy, done;
    logic [7:0]  cnt;
    logic [1:0]  scnt;
    logic        ovf;
    logic [2:0]  lvl;
    logic        vld;
    logic [15:0] pos;
  } vec_t;

  vec_t tab[$];

  task automatic add(input logic s, m, r, c, b, d, input logic [7:0] cn,
                     input logic [1:0] sc, input logic o, input logic [2:0] l,
                     input logic v, input logic [15:0] p);
    vec_t e;
    e.s = s; e.m = m; e.r = r; e.c = c; e.busy = b; e.done = d; e.cnt = cn;
    e.scnt = sc; e.ovf = o; e.lvl = l; e.vld = v; e.pos = p;
    tab.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs, record any pop, then step past the edge.
  task automatic cyc(input logic s, m, r, c);
    start = s; match = m; ev_ready = r; clear = c;
    if (ev_valid && r) popped.push_back(ev_pos);
    @(posedge clk);
    #1;
    start = 1'b0; match = 1'b0; ev_ready = 1'b0; clear = 1'b0;
  endtask

  task automatic win(input logic [15:0] mm, input logic [15:0] rm,
                     input int from, input int to, input int sp);
    for (int p = from; p <= to; p++) cyc(p == sp, mm[p], rm[p], 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // busy, done, count, sat count, overflow, level
  task automatic st(input string nm, input logic b, d, input logic [7:0] cn,
                    input logic [1:0] sc, input logic o, input logic [2:0] l);
    chk(nm, {busy, done, count, s_count, overflow, level},
            {b, d, cn, sc, o, l});
  endtask

  task automatic check_pops(input string nm);
    chk({nm, "_n"}, 64'(popped.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < popped.size(); i++)
      chk($sformatf("%s_%0d", nm, i), 64'(popped[i]), 64'(exp_q[i]));
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; start = 1'b0; match = 1'b0; ev_ready = 1'b0;

    #12;
    chk("reset", {busy, done, count, s_count, overflow, level, ev_valid, ev_pos},
                 {1'b0, 1'b0, 8'd0, 2'd0, 1'b0, 3'd0, 1'b0, 16'd0});
    #10 rst = 1'b0;
    @(posedge clk);
    #1;

    // Window of 16, matches at pos 2, 4, 9, no reads, then drain in DONE.
    add(1,0,0,0, 1,0, 0,0, 0, 0, 0, 0);
    add(0,0,0,0, 1,0, 0,0, 0, 0, 0, 0);
    add(0,0,0,0, 1,0, 0,0, 0, 0, 0, 0);
    add(0,1,0,0, 1,0, 1,1, 0, 1, 1, 2);
    add(0,0,0,0, 1,0, 1,1, 0, 1, 1, 2);
    add(0,1,0,0, 1,0, 2,2, 0, 2, 1, 2);
    for (int i = 0; i < 4; i++) add(0,0,0,0, 1,0, 2,2, 0, 2, 1, 2);
    add(0,1,0,0, 1,0, 3,3, 0, 3, 1, 2);
    for (int i = 0; i < 5; i++) add(0,0,0,0, 1,0, 3,3, 0, 3, 1, 2);
    add(0,0,0,0, 0,1, 3,3, 0, 3, 1, 2);
    add(0,1,0,0, 0,1, 3,3, 0, 3, 1, 2);
    add(0,0,1,0, 0,1, 3,3, 0, 2, 1, 4);
    add(0,0,1,0, 0,1, 3,3, 0, 1, 1, 9);
    add(0,0,1,0, 0,1, 3,3, 0, 0, 0, 0);

    for (int i = 0; i < tab.size(); i++) begin
      cyc(tab[i].s, tab[i].m, tab[i].r, tab[i].c);
      chk($sformatf("vec%0d", i),
          {busy, done, count, s_count, overflow, level, ev_valid,
           (tab[i].vld ? ev_pos : 16'd0)},
          {tab[i].busy, tab[i].done, tab[i].cnt, tab[i].scnt, tab[i].ovf,
           tab[i].lvl, tab[i].vld, tab[i].pos});
    end

    // Overflow: six matches into a 4-deep FIFO with no reads.
    cyc(1, 0, 0, 0);
    win(16'h0AAA, 16'h0000, 0, 15, -1);
    st("ovf_end", 0, 1, 6, 3, 1, 4);
    popped.delete();
    drain(5);
    exp_q = '{16'd1, 16'd3, 16'd5, 16'd7};
    check_pops("ovf_pop");
    st("ovf_hold", 0, 1, 6, 3, 1, 0);

    // Full FIFO with simultaneous push and pop at pos 12.
    popped.delete();
    cyc(1, 0, 0, 0);
    st("fp_start", 1, 0, 0, 0, 0, 0);
    win(16'h10AA, 16'h1000, 0, 12, -1);
    st("fp_pos12", 1, 0, 5, 3, 0, 4);
    chk("fp_head", 64'(ev_pos), 64'd3);
    win(16'h10AA, 16'h1000, 13, 15, -1);
    drain(5);
    exp_q = '{16'd1, 16'd3, 16'd5, 16'd7, 16'd12};
    check_pops("fp_pop");

    // Saturation with continuous reads; match on the last RUN cycle is logged.
    popped.delete();
    cyc(1, 0, 0, 0);
    win(16'h8055, 16'hFFFF, 0, 15, -1);
    drain(2);
    st("sat_end", 0, 1, 5, 3, 0, 0);
    exp_q = '{16'd0, 16'd2, 16'd4, 16'd6, 16'd15};
    check_pops("sat_pop");

    // start during RUN must not restart the window.
    popped.delete();
    cyc(1, 0, 0, 0);
    win(16'h0080, 16'h0000, 0, 15, 5);
    st("rst_ign", 0, 1, 1, 1, 0, 1);
    drain(2);
    exp_q = '{16'd7};
    check_pops("rst_ign_pop");

    // clear at pos 6 with two entries queued.
    cyc(1, 0, 0, 0);
    win(16'h000A, 16'h0000, 0, 5, -1);
    st("clr_pre", 1, 0, 2, 2, 0, 2);
    cyc(0, 0, 0, 1);
    st("clr_post", 0, 0, 0, 0, 0, 0);
    chk("clr_valid", 64'(ev_valid), 64'd0);
    cyc(0, 1, 0, 0);
    st("idle_match", 0, 0, 0, 0, 0, 0);

    // clear and start together stay in IDLE.
    cyc(1, 0, 0, 1);
    st("clr_start", 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    st("clr_start2", 0, 0, 0, 0, 0, 0);

    // Asynchronous reset mid-RUN, checked between clock edges.
    cyc(1, 0, 0, 0);
    win(16'h0004, 16'h0000, 0, 5, -1);
    st("ar_pre", 1, 0, 1, 1, 0, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_now", {busy, done, count, s_count, overflow, level, ev_valid, ev_pos},
                  {1'b0, 1'b0, 8'd0, 2'd0, 1'b0, 3'd0, 1'b0, 16'd0});
    rst = 1'b0;
    @(posedge clk);
    #1;
    st("ar_after", 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
